tetris_key_cmd: RTL and testbench

//   Consumes decoded PS/2 key events (valid_74/makeBreak_74/outCode_74) from keyboard_CLOCK74.

---
 rtl/tetris_key_cmd.sv | 232 +++++++++++++++++++++++
 tb/tb_tetris_key_cmd.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_key_cmd.sv
// Tetris keyboard command generator: PS/2 key events in, move commands out.
// Held-key tracking, DAS/ARR auto-repeat for LEFT/RIGHT/DOWN, command FIFO.
module tetris_key_cmd #(
    parameter logic [7:0] KEY_LEFT   = 8'h6B,
    parameter logic [7:0] KEY_RIGHT  = 8'h74,
    parameter logic [7:0] KEY_DOWN   = 8'h72,
    parameter logic [7:0] KEY_ROT    = 8'h75,
    parameter logic [7:0] KEY_DROP   = 8'h29,
    parameter int         DAS_CYC    = 12_622_500,
    parameter int         ARR_CYC    = 3_712_500,
    parameter int         CNT_W      = 24,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       CLOCK_74,
    input  logic       reset_n,
    input  logic       valid_74,
    input  logic       makeBreak_74,
    input  logic [7:0] outCode_74,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic [4:0] held,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CNT_W-1:0] DAS_LIM = CNT_W'(DAS_CYC - 1);
    localparam logic [CNT_W-1:0] ARR_LIM = CNT_W'(ARR_CYC - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_DAS,
        R_ARR
    } rep_state_t;

    logic [4:0]       key_oh;
    logic             ev_make;
    logic             ev_brk;
    logic [4:0]       held_q, held_d;

    rep_state_t       h_state_q, h_state_d;
    logic             hdir_q, hdir_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             h_tick;
    logic             h_make, h_switch, h_stop, h_brk_act;

    rep_state_t       d_state_q, d_state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             d_tick;
    logic             d_make, d_stop;

    logic             ev_push;
    logic [2:0]       ev_cmd;
    logic             h_grant, d_grant;
    logic             push;
    logic [2:0]       push_cmd;

    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, pop, wr;
    logic             ovf_q, ovf_d;

    // Scan code to one-hot key, bit order {DROP,ROT,DOWN,RIGHT,LEFT}
    always_comb begin
        key_oh = '0;
        case (outCode_74)
            KEY_LEFT:  key_oh[0] = 1'b1;
            KEY_RIGHT: key_oh[1] = 1'b1;
            KEY_DOWN:  key_oh[2] = 1'b1;
            KEY_ROT:   key_oh[3] = 1'b1;
            KEY_DROP:  key_oh[4] = 1'b1;
            default:   key_oh = '0;
        endcase
    end

    // Event qualification: typematic makes and stray breaks are filtered out
    always_comb begin
        ev_make   = valid_74 & makeBreak_74 & (|(key_oh & ~held_q));
        ev_brk    = valid_74 & ~makeBreak_74 & (|(key_oh & held_q));
        h_make    = ev_make & (key_oh[0] | key_oh[1]);
        h_brk_act = ev_brk & (h_state_q != R_IDLE)
                  & (hdir_q ? key_oh[1] : key_oh[0]);
        h_switch  = h_brk_act & (hdir_q ? held_q[0] : held_q[1]);
        h_stop    = h_brk_act & ~(hdir_q ? held_q[0] : held_q[1]);
        d_make    = ev_make & key_oh[2];
        d_stop    = ev_brk & key_oh[2];
        held_d    = held_q;
        if (ev_make) begin
            held_d = held_q | key_oh;
        end else if (ev_brk) begin
            held_d = held_q & ~key_oh;
        end
    end

    // Repeat tick outputs: counter parked at its terminal value
    always_comb begin
        h_tick = ((h_state_q == R_DAS) && (hcnt_q == DAS_LIM))
              || ((h_state_q == R_ARR) && (hcnt_q == ARR_LIM));
        d_tick = ((d_state_q == R_DAS) && (dcnt_q == DAS_LIM))
              || ((d_state_q == R_ARR) && (dcnt_q == ARR_LIM));
    end

    // Push arbitration: key event, then horizontal tick, then down tick
    always_comb begin
        ev_push = ev_make | h_switch;
        ev_cmd  = 3'd0;
        unique case (1'b1)
            key_oh[0]: ev_cmd = 3'd1;
            key_oh[1]: ev_cmd = 3'd2;
            key_oh[2]: ev_cmd = 3'd3;
            key_oh[3]: ev_cmd = 3'd4;
            key_oh[4]: ev_cmd = 3'd5;
            default:   ev_cmd = 3'd0;
        endcase
        if (h_switch) begin
            ev_cmd = hdir_q ? 3'd1 : 3'd2;
        end
        h_grant  = h_tick & ~h_stop & ~ev_push;
        d_grant  = d_tick & ~d_stop & ~ev_push & ~h_grant;
        push     = ev_push | h_grant | d_grant;
        push_cmd = ev_push ? ev_cmd
                 : h_grant ? (hdir_q ? 3'd2 : 3'd1)
                 : 3'd3;
    end

    // Horizontal engine next state
    always_comb begin
        h_state_d = h_state_q;
        hdir_d    = hdir_q;
        hcnt_d    = hcnt_q;
        if (h_make) begin
            hdir_d    = key_oh[1];
            hcnt_d    = '0;
            h_state_d = R_DAS;
        end else if (h_switch) begin
            hdir_d    = ~hdir_q;
            hcnt_d    = '0;
            h_state_d = R_DAS;
        end else if (h_stop) begin
            hcnt_d    = '0;
            h_state_d = R_IDLE;
        end else if (h_state_q != R_IDLE) begin
            if (!h_tick) begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end else if (h_grant) begin
                hcnt_d    = '0;
                h_state_d = R_ARR;
            end
        end
    end

    // Down engine next state
    always_comb begin
        d_state_d = d_state_q;
        dcnt_d    = dcnt_q;
        if (d_make) begin
            dcnt_d    = '0;
            d_state_d = R_DAS;
        end else if (d_stop) begin
            dcnt_d    = '0;
            d_state_d = R_IDLE;
        end else if (d_state_q != R_IDLE) begin
            if (!d_tick) begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end else if (d_grant) begin
                dcnt_d    = '0;
                d_state_d = R_ARR;
            end
        end
    end

    // FIFO control: a push into a full FIFO survives only with a same-cycle pop
    always_comb begin
        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = (count_q != '0) & cmd_ready;
        wr      = push & (~full | pop);
        ovf_d   = push & full & ~pop;
        wptr_d  = wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (wr && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers for keys, both engines and the FIFO
    always_ff @(posedge CLOCK_74 or negedge reset_n) begin
        if (!reset_n) begin
            held_q    <= '0;
            h_state_q <= R_IDLE;
            hdir_q    <= 1'b0;
            hcnt_q    <= '0;
            d_state_q <= R_IDLE;
            dcnt_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else begin
            held_q    <= held_d;
            h_state_q <= h_state_d;
            hdir_q    <= hdir_d;
            hcnt_q    <= hcnt_d;
            d_state_q <= d_state_d;
            dcnt_q    <= dcnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            if (wr) begin
                mem_q[wptr_q] <= push_cmd;
            end
        end
    end

    // Outputs straight from registered state
    always_comb begin
        cmd_valid = (count_q != '0);
        cmd       = cmd_valid ? mem_q[rptr_q] : 3'd0;
        held      = held_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_tetris_key_cmd.sv
// Directed bench for tetris_key_cmd with short DAS/ARR timing.
// Logs every accepted command with its cycle index and checks sequences.
module tb_tetris_key_cmd;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic       mb;
    logic [7:0] code;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic [4:0] held;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int       lc   [$];
    logic [2:0] lcmd [$];

    tetris_key_cmd #(
        .DAS_CYC   (8),
        .ARR_CYC   (3),
        .CNT_W     (24),
        .FIFO_DEPTH(4)
    ) dut (
        .CLOCK_74    (clk),
        .reset_n     (rst_n),
        .valid_74    (valid),
        .makeBreak_74(mb),
        .outCode_74  (code),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .held        (held),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (rst_n && cmd_valid && cmd_ready) begin
            lc.push_back(cyc);
            lcmd.push_back(cmd);
        end
    end

    // Called at a negedge; event is sampled at posedge cyc+1
    task automatic ev(input bit mk, input logic [7:0] c);
        valid = 1'b1;
        mb    = mk;
        code  = c;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=0", cmd_valid);
        end
        total++;
        if (cmd !== 3'd0) begin
            bad++;
            $display("FAIL reset_cmd got=%0d exp=0", cmd);
        end
        total++;
        if (held !== 5'd0) begin
            bad++;
            $display("FAIL reset_held got=%b exp=00000", held);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got=%b exp=0", overflow);
        end
    endtask

    task automatic test_hold_left();
        int e;
        int off [4] = '{0, 8, 11, 14};
        lc.delete();
        lcmd.delete();
        e = cyc + 1;
        ev(1'b1, 8'h6B);
        total++;
        if (held !== 5'b00001) begin
            bad++;
            $display("FAIL hold_held got=%b exp=00001", held);
        end
        wait_until(e + 15);
        ev(1'b0, 8'h6B);
        total++;
        if (held !== 5'b00000) begin
            bad++;
            $display("FAIL hold_release got=%b exp=00000", held);
        end
        wait_until(e + 40);
        total++;
        if (lc.size() != 4) begin
            bad++;
            $display("FAIL hold_count got=%0d exp=4", lc.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < lc.size()) begin
                total++;
                if (lc[i] != e + off[i] || lcmd[i] !== 3'd1) begin
                    bad++;
                    $display("FAIL hold_cmd%0d got=@%0d:%0d exp=@%0d:1",
                             i, lc[i] - e, lcmd[i], off[i]);
                end
            end
        end
    endtask

    task automatic test_left_right();
        int e;
        int         off [4] = '{0, 2, 4, 12};
        logic [2:0] exc [4] = '{3'd1, 3'd2, 3'd1, 3'd1};
        lc.delete();
        lcmd.delete();
        e = cyc + 1;
        ev(1'b1, 8'h6B);
        wait_until(e + 1);
        ev(1'b1, 8'h74);
        total++;
        if (held !== 5'b00011) begin
            bad++;
            $display("FAIL lr_held got=%b exp=00011", held);
        end
        wait_until(e + 3);
        ev(1'b0, 8'h74);
        wait_until(e + 13);
        ev(1'b0, 8'h6B);
        wait_until(e + 35);
        total++;
        if (lc.size() != 4) begin
            bad++;
            $display("FAIL lr_count got=%0d exp=4", lc.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < lc.size()) begin
                total++;
                if (lc[i] != e + off[i] || lcmd[i] !== exc[i]) begin
                    bad++;
                    $display("FAIL lr_cmd%0d got=@%0d:%0d exp=@%0d:%0d",
                             i, lc[i] - e, lcmd[i], off[i], exc[i]);
                end
            end
        end
    endtask

    task automatic test_oneshot();
        int e;
        lc.delete();
        lcmd.delete();
        e = cyc + 1;
        ev(1'b1, 8'h75);
        total++;
        if (held !== 5'b01000) begin
            bad++;
            $display("FAIL rot_held got=%b exp=01000", held);
        end
        ev(1'b1, 8'h75);
        ev(1'b1, 8'h75);
        ev(1'b0, 8'h75);
        ev(1'b1, 8'h29);
        total++;
        if (held !== 5'b10000) begin
            bad++;
            $display("FAIL drop_held got=%b exp=10000", held);
        end
        ev(1'b0, 8'h29);
        wait_until(e + 20);
        total++;
        if (lc.size() != 2) begin
            bad++;
            $display("FAIL oneshot_count got=%0d exp=2", lc.size());
        end
        if (lc.size() >= 2) begin
            total++;
            if (lc[0] != e || lcmd[0] !== 3'd4) begin
                bad++;
                $display("FAIL oneshot_rot got=@%0d:%0d exp=@0:4",
                         lc[0] - e, lcmd[0]);
            end
            total++;
            if (lc[1] != e + 4 || lcmd[1] !== 3'd5) begin
                bad++;
                $display("FAIL oneshot_drop got=@%0d:%0d exp=@4:5",
                         lc[1] - e, lcmd[1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] keys [5] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29};
        lc.delete();
        lcmd.delete();
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) ev(1'b1, keys[i]);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early got=%b exp=0", overflow);
        end
        ev(1'b1, keys[4]);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pulse got=%b exp=1", overflow);
        end
        total++;
        if (held !== 5'b11111) begin
            bad++;
            $display("FAIL ovf_held got=%b exp=11111", held);
        end
        ev(1'b0, keys[0]);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_one_cycle got=%b exp=0", overflow);
        end
        for (int i = 1; i < 5; i++) ev(1'b0, keys[i]);
        total++;
        if (held !== 5'b00000 || cmd_valid !== 1'b1 || cmd !== 3'd1) begin
            bad++;
            $display("FAIL ovf_queued got=%b/%b/%0d exp=00000/1/1",
                     held, cmd_valid, cmd);
        end
        cmd_ready = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (lc.size() != 4) begin
            bad++;
            $display("FAIL ovf_count got=%0d exp=4", lc.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < lc.size()) begin
                total++;
                if (lcmd[i] !== 3'(i + 1)) begin
                    bad++;
                    $display("FAIL ovf_order%0d got=%0d exp=%0d",
                             i, lcmd[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        int         off [5] = '{0, 1, 8, 9, 10};
        logic [2:0] exc [5] = '{3'd1, 3'd3, 3'd4, 3'd1, 3'd3};
        lc.delete();
        lcmd.delete();
        e = cyc + 1;
        ev(1'b1, 8'h6B);
        ev(1'b1, 8'h72);
        wait_until(e + 7);
        ev(1'b1, 8'h75);
        wait_until(e + 10);
        ev(1'b0, 8'h6B);
        ev(1'b0, 8'h72);
        ev(1'b0, 8'h75);
        wait_until(e + 30);
        total++;
        if (lc.size() != 5) begin
            bad++;
            $display("FAIL arb_count got=%0d exp=5", lc.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < lc.size()) begin
                total++;
                if (lc[i] != e + off[i] || lcmd[i] !== exc[i]) begin
                    bad++;
                    $display("FAIL arb_cmd%0d got=@%0d:%0d exp=@%0d:%0d",
                             i, lc[i] - e, lcmd[i], off[i], exc[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int e;
        cmd_ready = 1'b0;
        e = cyc + 1;
        ev(1'b1, 8'h6B);
        wait_until(e + 9);
        total++;
        if (cmd_valid !== 1'b1 || held !== 5'b00001) begin
            bad++;
            $display("FAIL arst_pre got=%b/%b exp=1/00001", cmd_valid, held);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
            bad++;
            $display("FAIL arst_fifo got=%b/%0d exp=0/0", cmd_valid, cmd);
        end
        total++;
        if (held !== 5'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL arst_held got=%b/%b exp=00000/0", held, overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        lc.delete();
        lcmd.delete();
        repeat (25) @(negedge clk);
        total++;
        if (lc.size() != 0 || cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_norepeat got=%0d/%b exp=0/0",
                     lc.size(), cmd_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        mb        = 1'b0;
        code      = 8'h00;
        cmd_ready = 1'b1;
        #1;
        test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_hold_left();
        test_left_right();
        test_oneshot();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
